// File: rtl/rtc_pkg.sv
// ---------------------------------------------------------------------------
// rtc_pkg
// Shared types and constants for the stopwatch display scanner.
//   scan_state_t : scanner FSM states
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : only segment g lit, shown for non-BCD nibbles
//   SEG_LUT      : nibble -> active-low {g,f,e,d,c,b,a}; A-F map to the dash
//   bcd_invalid  : true when any of the six nibbles exceeds 9
// ---------------------------------------------------------------------------
package rtc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CAPT = 2'd2,
      SCAN = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Index 15 is leftmost.
   localparam logic [15:0][6:0] SEG_LUT = {
      SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic bcd_invalid(input logic [23:0] val);
      logic bad;
      bad = 1'b0;
      for (int n = 0; n < 6; n++) begin
         bad = bad | (val[4*n +: 4] > 4'd9);
      end
      return bad;
   endfunction

endpackage

// File: rtl/rtc_bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// rtc_bcd_to_7seg
// Combinational BCD nibble to active-low 7-segment decoder.
//   i_bcd : 4-bit digit value
//   o_seg : segments {g,f,e,d,c,b,a}, active-low; values above 9 give a dash
// ---------------------------------------------------------------------------
module rtc_bcd_to_7seg
   import rtc_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_LUT[i_bcd];

endmodule

// File: rtl/rtc_display_scan.sv
// ---------------------------------------------------------------------------
// rtc_display_scan
// Reads the 24-bit BCD stopwatch count once per frame and multiplexes the
// six digits onto a common-anode 7-segment display.
//   i_rtcclk      : clock (counter domain)
//   i_reset_n     : async active-low reset
//   i_dispenb     : display enable; low blanks the display and idles
//   i_lzb         : leading-zero blanking enable
//   i_count       : BCD count, digit n = i_count[4n+3:4n]
//   o_latchcount  : one-cycle latch request to the counter
//   o_seg         : segments {g,f,e,d,c,b,a}, active-low
//   o_dp          : decimal point, active-low
//   o_an          : digit anodes, active-low one-hot-cold
//   o_bcd_err     : last snapshot held a nibble above 9
//
// state | meaning
// IDLE  | display blank, waiting for i_dispenb
// REQ   | o_latchcount high, anodes off
// CAPT  | count snapshot taken, digit 0 prepared
// SCAN  | digit r_digit lit for SCAN_DIV cycles each
// ---------------------------------------------------------------------------
module rtc_display_scan
   import rtc_pkg::*;
#(
   parameter int         SCAN_DIV   = 1000,
   parameter int         NUM_DIGITS = 6,
   parameter logic [5:0] DP_MASK    = 6'b010100
)(
   input  logic        i_rtcclk,
   input  logic        i_reset_n,
   input  logic        i_dispenb,
   input  logic        i_lzb,
   input  logic [23:0] i_count,
   output logic        o_latchcount,
   output logic [6:0]  o_seg,
   output logic        o_dp,
   output logic [5:0]  o_an,
   output logic        o_bcd_err
);

   generate
      if (NUM_DIGITS != 6) begin : g_bad_digits
         $error("rtc_display_scan: NUM_DIGITS must be 6");
      end
   endgenerate

   localparam int              DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]      LAST_DIGIT = 3'(NUM_DIGITS - 1);
   localparam logic [7:0]      DP_EXT     = {2'b00, DP_MASK};

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  w_div_nxt;
   logic [2:0]        r_digit;
   logic [2:0]        w_digit_nxt;
   logic [23:0]       r_snap;
   logic              r_bcd_err;
   logic              r_latch;
   logic [6:0]        r_seg;
   logic              r_dp;
   logic [5:0]        r_an;

   logic              w_clear;
   logic              w_show;
   logic              w_capt;
   logic [3:0]        w_snap_nib;
   logic [3:0]        w_nib;
   logic [6:0]        w_dec_seg;
   logic [7:0]        w_zero_from;
   logic              w_blank;
   logic [5:0]        w_an_dig;

   // ---------------- FSM ----------------
   always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_div   <= '0;
         r_digit <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_digit <= w_digit_nxt;
      end
   end

   // w_show loads the output registers with digit w_digit_nxt;
   // w_clear blanks them.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_digit_nxt = r_digit;
      w_clear     = 1'b0;
      w_show      = 1'b0;
      w_capt      = 1'b0;
      if (!i_dispenb) begin
         w_state_nxt = IDLE;
         w_clear     = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = REQ;
               w_clear     = 1'b1;
            end
            REQ: begin
               w_state_nxt = CAPT;
               w_clear     = 1'b1;
            end
            CAPT: begin
               w_state_nxt = SCAN;
               w_capt      = 1'b1;
               w_div_nxt   = '0;
               w_digit_nxt = '0;
               w_show      = 1'b1;
            end
            SCAN: begin
               if (r_div == DIV_LAST) begin
                  w_div_nxt = '0;
                  if (r_digit == LAST_DIGIT) begin
                     w_state_nxt = REQ;
                     w_clear     = 1'b1;
                  end else begin
                     w_digit_nxt = r_digit + 3'd1;
                     w_show      = 1'b1;
                  end
               end else begin
                  w_div_nxt = r_div + 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_clear     = 1'b1;
            end
         endcase
      end
   end

   // ---------------- snapshot ----------------
   always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_snap    <= '0;
         r_bcd_err <= 1'b0;
      end else if (w_capt) begin
         r_snap    <= i_count;
         r_bcd_err <= bcd_invalid(i_count);
      end
   end

   // ---------------- digit decode ----------------
   always_comb begin
      case (w_digit_nxt)
         3'd0:    w_snap_nib = r_snap[3:0];
         3'd1:    w_snap_nib = r_snap[7:4];
         3'd2:    w_snap_nib = r_snap[11:8];
         3'd3:    w_snap_nib = r_snap[15:12];
         3'd4:    w_snap_nib = r_snap[19:16];
         3'd5:    w_snap_nib = r_snap[23:20];
         default: w_snap_nib = 4'd0;
      endcase
   end

   // Digit 0 is prepared during CAPT, before the snapshot register holds the
   // new count, so it is taken straight from the input.
   assign w_nib = (r_state == CAPT) ? i_count[3:0] : w_snap_nib;

   rtc_bcd_to_7seg u_dec (
      .i_bcd (w_nib),
      .o_seg (w_dec_seg)
   );

   // w_zero_from[k]: snapshot digits k..5 are all zero.
   genvar g;
   generate
      for (g = 0; g < 6; g++) begin : g_zero
         assign w_zero_from[g] = (r_snap[23:4*g] == '0);
      end
   endgenerate
   assign w_zero_from[7:6] = 2'b00;

   assign w_blank = i_lzb && (w_digit_nxt != 3'd0) && w_zero_from[w_digit_nxt];

   always_comb begin
      case (w_digit_nxt)
         3'd0:    w_an_dig = 6'h3E;
         3'd1:    w_an_dig = 6'h3D;
         3'd2:    w_an_dig = 6'h3B;
         3'd3:    w_an_dig = 6'h37;
         3'd4:    w_an_dig = 6'h2F;
         3'd5:    w_an_dig = 6'h1F;
         default: w_an_dig = 6'h3F;
      endcase
   end

   // ---------------- registered outputs ----------------
   always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_latch <= 1'b0;
         r_seg   <= SEG_BLANK;
         r_dp    <= 1'b1;
         r_an    <= 6'h3F;
      end else begin
         r_latch <= (w_state_nxt == REQ);
         if (w_clear) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_an  <= 6'h3F;
         end else if (w_show) begin
            r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
            r_dp  <= ~(DP_EXT[w_digit_nxt] & ~w_blank);
            r_an  <= w_an_dig;
         end
      end
   end

   assign o_latchcount = r_latch;
   assign o_seg        = r_seg;
   assign o_dp         = r_dp;
   assign o_an         = r_an;
   assign o_bcd_err    = r_bcd_err;

endmodule

// File: tb/tb_rtc_display_scan.sv
// ---------------------------------------------------------------------------
// tb_rtc_display_scan
// Directed bench: one scanner with SCAN_DIV=4 for frame checks, one with
// SCAN_DIV=1 for the single-cycle-per-digit case. Outputs sampled on negedge.
// ---------------------------------------------------------------------------
module tb_rtc_display_scan;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dispenb;
   logic        lzb;
   logic [23:0] count;

   logic        latch, dp, err;
   logic [6:0]  seg;
   logic [5:0]  an;
   logic        latch1, dp1, err1;
   logic [6:0]  seg1;
   logic [5:0]  an1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rtc_display_scan #(.SCAN_DIV(DIV), .NUM_DIGITS(6), .DP_MASK(6'b010100)) u_dut (
      .i_rtcclk     (clk),
      .i_reset_n    (rst_n),
      .i_dispenb    (dispenb),
      .i_lzb        (lzb),
      .i_count      (count),
      .o_latchcount (latch),
      .o_seg        (seg),
      .o_dp         (dp),
      .o_an         (an),
      .o_bcd_err    (err)
   );

   rtc_display_scan #(.SCAN_DIV(1), .NUM_DIGITS(6), .DP_MASK(6'b010100)) u_dut1 (
      .i_rtcclk     (clk),
      .i_reset_n    (rst_n),
      .i_dispenb    (dispenb),
      .i_lzb        (lzb),
      .i_count      (count),
      .o_latchcount (latch1),
      .o_seg        (seg1),
      .o_dp         (dp1),
      .o_an         (an1),
      .o_bcd_err    (err1)
   );

   task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [5:0] an_exp(input int k);
      logic [5:0] v;
      v = 6'd1 << k;
      return ~v;
   endfunction

   task automatic wait_latch(input string tag);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (latch) break;
      end
      chk_val({tag, " latch seen"}, latch, 1);
   endtask

   // Entered on the negedge of a REQ cycle; leaves on the next REQ negedge.
   task automatic check_frame(input string tag, input logic [5:0][6:0] segs,
                              input logic [5:0] dps, input logic err_exp,
                              input logic [23:0] mid);
      chk_val({tag, " latch req"}, latch, 1);
      @(negedge clk);
      chk_val({tag, " latch capt"}, latch, 0);
      chk_val({tag, " an capt"}, an, 6'h3F);
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         chk_val($sformatf("%s an d%0d", tag, k), an, an_exp(k));
         chk_val($sformatf("%s seg d%0d", tag, k), seg, segs[k]);
         chk_val($sformatf("%s dp d%0d", tag, k), dp, dps[k]);
         if (k == 0) chk_val({tag, " bcd_err"}, err, err_exp);
         if (k == 2) count = mid;
         repeat (DIV) @(negedge clk);
      end
      chk_val({tag, " frame 26"}, latch, 1);
   endtask

   logic [5:0][6:0] seg_a;

   initial begin
      rst_n   = 1'b0;
      dispenb = 1'b0;
      lzb     = 1'b0;
      count   = 24'h012345;
      seg_a   = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
      repeat (3) @(negedge clk);
      chk_val("rst latch", latch, 0);
      chk_val("rst seg", seg, 7'h7F);
      chk_val("rst dp", dp, 1);
      chk_val("rst an", an, 6'h3F);
      chk_val("rst err", err, 0);
      chk_val("rst err1", err1, 0);
      rst_n = 1'b1;
      @(negedge clk);
      dispenb = 1'b1;

      // SCAN_DIV=1: one cycle per digit, frame of 8 cycles
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (latch1) break;
      end
      chk_val("div1 latch", latch1, 1);
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         chk_val($sformatf("div1 an d%0d", k), an1, an_exp(k));
         chk_val($sformatf("div1 seg d%0d", k), seg1, seg_a[k]);
         chk_val($sformatf("div1 dp d%0d", k), dp1, (k == 2 || k == 4) ? 1'b0 : 1'b1);
         @(negedge clk);
      end
      chk_val("div1 frame 8", latch1, 1);
      @(negedge clk);
      @(negedge clk);
      chk_val("div1 an wrap", an1, 6'h3E);

      // SCAN_DIV=4 frames
      wait_latch("A");
      check_frame("A", seg_a, 6'b101011, 1'b0, 24'h012345);
      count = 24'h000007; lzb = 1'b1;
      check_frame("B", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}, 6'h3F, 1'b0, 24'h000007);
      lzb = 1'b0;
      check_frame("C", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}, 6'b101011, 1'b0, 24'h000007);
      count = 24'h00A009; lzb = 1'b1;
      check_frame("D", {7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40, 7'h10}, 6'b111011, 1'b1, 24'h00A009);
      count = 24'h000009; lzb = 1'b0;
      check_frame("E", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10}, 6'b101011, 1'b0, 24'h000009);
      count = 24'h123456;
      check_frame("F", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'b101011, 1'b0, 24'h987654);
      check_frame("G", {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}, 6'b101011, 1'b0, 24'h987654);

      // display enable drop mid-scan
      count = 24'h00F000;
      @(negedge clk);
      @(negedge clk);
      chk_val("H bcd_err", err, 1);
      chk_val("H an d0", an, 6'h3E);
      chk_val("H seg d0", seg, 7'h40);
      repeat (5) @(negedge clk);
      dispenb = 1'b0;
      @(negedge clk);
      chk_val("off an", an, 6'h3F);
      chk_val("off seg", seg, 7'h7F);
      chk_val("off dp", dp, 1);
      chk_val("off err held", err, 1);
      repeat (10) @(negedge clk);
      chk_val("idle latch", latch, 0);
      chk_val("idle an", an, 6'h3F);
      dispenb = 1'b1;
      @(negedge clk);
      chk_val("reenable latch", latch, 1);
      @(negedge clk);
      @(negedge clk);
      chk_val("reenable an", an, 6'h3E);
      chk_val("reenable err", err, 1);

      // asynchronous reset between clock edges
      #2 rst_n = 1'b0;
      #1;
      chk_val("arst latch", latch, 0);
      chk_val("arst seg", seg, 7'h7F);
      chk_val("arst dp", dp, 1);
      chk_val("arst an", an, 6'h3F);
      chk_val("arst err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/rtc_display_scan.md
Name: rtc_display_scan

Overview:
- Reader-side consumer of the 24-bit BCD stopwatch counter.
- Each frame it pulses a latch request to the counter and captures the 6-digit BCD snapshot one cycle later.
- It then time-multiplexes the six digits onto a common-anode 7-segment display, with decimal points, leading-zero blanking and invalid-BCD flagging.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays lit; legal range >=1.
- NUM_DIGITS, 6: digit count; fixed to 6 for a 24-bit count. Any other value is a synthesis-time error.
- DP_MASK, 6'b010100: digits whose decimal point is lit (bit n = digit n).

Ports:
- i_rtcclk  input  1  block clock, same domain as the counter.
- i_reset_n  input  1  asynchronous active-low reset.
- i_dispenb  input  1  display enable; 0 blanks the display and idles the block.
- i_lzb  input  1  leading-zero blanking enable.
- i_count  input  24  BCD count from the counter; digit n = i_count[4n+3:4n].
- o_latchcount  output  1  one-cycle latch request to the counter.
- o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- o_dp  output  1  decimal point, active-low.
- o_an  output  6  digit anode select, active-low, one-hot-cold.
- o_bcd_err  output  1  high when the last captured snapshot held any nibble > 9.

Behaviour:
- Reset (async assert, sync release): state IDLE, o_latchcount=0, o_seg=7'h7F, o_dp=1, o_an=6'h3F, o_bcd_err=0, snapshot=0, digit index=0, divider=0.
- States: IDLE -> REQ -> CAPT -> SCAN -> REQ ...
  - IDLE: display blank. Go to REQ on the first cycle with i_dispenb=1.
  - REQ: o_latchcount=1 for exactly this one cycle. Anodes off. Always go to CAPT.
  - CAPT: register i_count into the snapshot. o_bcd_err <= OR over digits of (nibble>9). Digit index=0, divider=0. Go to SCAN.
  - SCAN: drive digit index k for SCAN_DIV cycles; divider counts 0..SCAN_DIV-1.
    - When the divider wraps, k increments.
    - After digit NUM_DIGITS-1 completes, go to REQ.
- Frame length: 2 + 6*SCAN_DIV cycles. Latch-to-capture latency: exactly 1 cycle.
- Outputs are registered: o_an/o_seg/o_dp for digit k appear on the cycle SCAN is entered, or on the cycle after a divider wrap.
- Anode: o_an[k]=0, all other bits 1. Digit 0 (LSD) maps to o_an[0].
- Segment decode, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
- Invalid nibble (A-F): show a dash, o_seg=7'h3F. The digit is never blanked.
- Leading-zero blanking, with i_lzb=1 sampled during SCAN:
  - Digit k is blanked (o_seg=7'h7F, o_dp=1, anode still active) if k>0 and every snapshot digit from k up to 5 equals 0.
  - Digit 0 is never blanked.
- o_dp=0 when DP_MASK[k]=1 and the digit is not blanked.
- i_dispenb falls in any state: next cycle go to IDLE and blank all outputs. o_bcd_err and the snapshot are held.
- i_count is sampled only in CAPT; changes during SCAN have no effect until the next frame.
- SCAN_DIV=1: one cycle per digit, with no skipped or doubled digits.

Decomposition:
- Shared package rtc_pkg:
  - state enum scan_state_t {IDLE, REQ, CAPT, SCAN}.
  - constants SEG_BLANK=7'h7F, SEG_DASH=7'h3F.
  - 16-entry segment lookup constant.
- One sub-module: rtc_bcd_to_7seg. Purely combinational nibble -> 7-bit active-low segments, returning the dash for values > 9. Instantiated once on the muxed digit.

Test Plan:
- Reset, then i_dispenb=1, SCAN_DIV=4, i_count=24'h012345:
  - o_latchcount pulses high 1 cycle.
  - Digits 0..5 show seg 12,19,30,24,79,40.
  - o_an walks 3E,3D,3B,37,2F,1F; frame repeats every 26 cycles.
- i_count=24'h000007, i_lzb=1:
  - digits 1-5 o_seg=7F, digit 0 o_seg=78.
  - with i_lzb=0, digits 1-5 show 40.
- i_count=24'h00A009:
  - digit 3 shows 3F; o_bcd_err=1 from CAPT onward.
  - next frame with 24'h000009: o_bcd_err=0.
- DP_MASK default, i_count=24'h123456, i_lzb=0: o_dp=0 only on digits 2 and 4.
- i_count changed mid-SCAN: displayed digits unchanged until after the next REQ/CAPT.
- i_dispenb dropped mid-SCAN, and i_reset_n asserted mid-frame:
  - dispenb drop: next cycle o_an=3F, o_seg=7F, state IDLE.
  - reset: all outputs immediately at reset values, without waiting for a clock edge.
